// File: rtl/ipv4_pkg.sv
// Shared IPv4 transmit definitions: header field widths, protocol numbers,
// the TX scheduler state encoding and a saturating length accumulator.
package ipv4_pkg;

  localparam int PROT_W    = 8;
  localparam int TOT_LEN_W = 16;

  localparam logic [PROT_W-1:0] PROT_ICMP = 8'd1;
  localparam logic [PROT_W-1:0] PROT_UDP  = 8'd17;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARB   = 5'b00010,
    XFER  = 5'b00100,
    DRAIN = 5'b01000,
    GAP   = 5'b10000
  } sched_state_t;

  // Running packet length; pins at all-ones instead of wrapping.
  function automatic logic [TOT_LEN_W-1:0] sat_add_len(
    input logic [TOT_LEN_W-1:0] acc,
    input logic [TOT_LEN_W-1:0] inc
  );
    logic [TOT_LEN_W:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return sum[TOT_LEN_W] ? '1 : sum[TOT_LEN_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request scanning upward
// from ptr+1, wrapping modulo N. Reports the winner one-hot and as an index.
module rr_arb #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] index
);

  always_comb begin : scan
    logic           found;
    logic [IDX_W:0] cand;
    // NOTE: every output gets a default before the loop so no path can
    // leave a value unassigned and infer a latch.
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        onehot[cand[IDX_W-1:0]]   = 1'b1;
        index                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ipv4_tx_sched.sv
// Packet-granular round-robin scheduler feeding one IPv4 TX engine from
// N_REQ transport requesters, with overrun/cancel abort and drain.
module ipv4_tx_sched #(
  parameter  int N_REQ   = 2,
  parameter  int DATA_W  = 16,
  parameter  int LEN_W   = $clog2(DATA_W/8) + 1,
  parameter  int PROT_W  = ipv4_pkg::PROT_W,
  parameter  int GAP_CYC = 1,
  parameter  int MAX_LEN = 1480,
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ*LEN_W-1:0]  req_len_i,
  input  logic [N_REQ-1:0]        req_last_i,
  input  logic [N_REQ*PROT_W-1:0] req_prot_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic                    ready_i,
  input  logic                    cancel_i,
  output logic                    valid_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [LEN_W-1:0]        len_o,
  output logic                    last_o,
  output logic [PROT_W-1:0]       prot_o,
  output logic [IDX_W-1:0]        owner_o,
  output logic                    abort_o,
  output logic                    busy_o
);

  import ipv4_pkg::TOT_LEN_W, ipv4_pkg::sched_state_t, ipv4_pkg::sat_add_len;
  import ipv4_pkg::IDLE, ipv4_pkg::ARB, ipv4_pkg::XFER, ipv4_pkg::DRAIN, ipv4_pkg::GAP;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  sched_state_t         state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [TOT_LEN_W-1:0] byte_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  logic [N_REQ-1:0]     win_onehot;
  logic [IDX_W-1:0]     win_idx;

  logic                 own_valid;
  logic                 own_last;
  logic [LEN_W-1:0]     own_len;
  logic [TOT_LEN_W-1:0] cnt_next;
  logic                 in_xfer;
  logic                 in_drain;
  logic                 cancel_hit;
  logic                 beat_fire;
  logic                 overrun;

  rr_arb #(.N(N_REQ)) u_rr_arb (
    .req    (req_valid_i),
    .ptr    (rr_ptr),
    .onehot (win_onehot),
    .index  (win_idx)
  );

  // The datapath is a pure mux on the registered owner: zero added latency.
  assign own_valid = req_valid_i[owner_o];
  assign own_last  = req_last_i[owner_o];
  assign own_len   = req_len_i[owner_o*LEN_W +: LEN_W];
  assign data_o    = req_data_i[owner_o*DATA_W +: DATA_W];
  assign len_o     = own_len;
  assign last_o    = own_last;

  // Gating on reset keeps a mid-packet reset from leaking a beat or an abort.
  assign in_xfer    = (state == XFER)  && !reset;
  assign in_drain   = (state == DRAIN) && !reset;
  assign cancel_hit = in_xfer && cancel_i;
  assign valid_o    = in_xfer && own_valid && !cancel_i;
  assign beat_fire  = valid_o && ready_i;
  assign cnt_next   = sat_add_len(byte_cnt, TOT_LEN_W'(own_len));
  assign overrun    = beat_fire && !own_last && (32'(cnt_next) >= MAX_LEN);
  assign abort_o    = cancel_hit || overrun;

  // A cancelled beat is left with the requester so DRAIN can consume it,
  // including a last beat, which keeps the next packet aligned.
  always_comb begin
    req_ready_o = '0;
    if (in_xfer) begin
      req_ready_o[owner_o] = ready_i && !cancel_i;
    end else if (in_drain) begin
      req_ready_o[owner_o] = 1'b1;
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= IDX_W'(N_REQ - 1);
      owner_o  <= '0;
      prot_o   <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid_i) begin
            state  <= ARB;
            busy_o <= 1'b1;
          end
        end
        ARB: begin
          byte_cnt <= '0;
          if (|win_onehot) begin
            state   <= XFER;
            owner_o <= win_idx;
            prot_o  <= req_prot_i[win_idx*PROT_W +: PROT_W];
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        XFER: begin
          if (cancel_i) begin
            state <= DRAIN;
          end else if (beat_fire) begin
            byte_cnt <= cnt_next;
            if (own_last) begin
              rr_ptr  <= owner_o;
              gap_cnt <= '0;
              if (GAP_CYC == 0) begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end else begin
                state <= GAP;
              end
            end else if (overrun) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (own_valid && own_last) begin
            rr_ptr  <= owner_o;
            gap_cnt <= '0;
            if (GAP_CYC == 0) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_tx_sched.sv
// Directed bench for ipv4_tx_sched: queue-driven requesters, a beat monitor
// and cycle-exact checks of grant, stall, overrun, cancel and reset behaviour.
module tb_ipv4_tx_sched;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  l;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_len;
  logic [1:0]  req_last;
  logic [15:0] req_prot;
  logic [1:0]  req_ready;
  logic        ready;
  logic        cancel;
  logic        valid_o;
  logic [15:0] data_o;
  logic [1:0]  len_o;
  logic        last_o;
  logic [7:0]  prot_o;
  logic [0:0]  owner_o;
  logic        abort_o;
  logic        busy_o;

  beat_t       src0[$];
  beat_t       src1[$];
  logic [15:0] rx[$];
  logic [15:0] exp_rx[$];
  int          grants[$];
  int          abort_cnt = 0;
  logic        in_pkt = 1'b0;
  logic        pop0 = 1'b0;
  logic        pop1 = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  ipv4_tx_sched #(
    .N_REQ   (2),
    .DATA_W  (16),
    .GAP_CYC (1),
    .MAX_LEN (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_len_i   (req_len),
    .req_last_i  (req_last),
    .req_prot_i  (req_prot),
    .req_ready_o (req_ready),
    .ready_i     (ready),
    .cancel_i    (cancel),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .len_o       (len_o),
    .last_o      (last_o),
    .prot_o      (prot_o),
    .owner_o     (owner_o),
    .abort_o     (abort_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int who, input logic [15:0] base, input int nbeats);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.d    = base + 16'(k);
      b.l    = 2'd2;
      b.last = (k == nbeats - 1);
      if (who == 0) src0.push_back(b);
      else          src1.push_back(b);
    end
  endtask

  task automatic drive_src();
    req_valid = '0;
    req_data  = '0;
    req_len   = '0;
    req_last  = '0;
    if (src0.size() != 0) begin
      req_valid[0]    = 1'b1;
      req_data[15:0]  = src0[0].d;
      req_len[1:0]    = src0[0].l;
      req_last[0]     = src0[0].last;
    end
    if (src1.size() != 0) begin
      req_valid[1]    = 1'b1;
      req_data[31:16] = src1[0].d;
      req_len[3:2]    = src1[0].l;
      req_last[1]     = src1[0].last;
    end
  endtask

  // Requesters: retire the accepted head beat just after each rising edge.
  initial begin
    drive_src();
    forever begin
      @(posedge clk);
      #2;
      if (pop0) void'(src0.pop_front());
      if (pop1) void'(src1.pop_front());
      drive_src();
    end
  end

  // Monitor samples mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    pop0 = req_valid[0] && req_ready[0];
    pop1 = req_valid[1] && req_ready[1];
    if (reset) begin
      in_pkt = 1'b0;
    end else begin
      if (valid_o && ready) begin
        rx.push_back(data_o);
        if (!in_pkt) grants.push_back(int'(owner_o));
        in_pkt = !last_o;
      end
      if (abort_o) begin
        abort_cnt++;
        in_pkt = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    rx.delete();
    exp_rx.delete();
    grants.delete();
    abort_cnt = 0;
  endtask

  task automatic check_rx(input string tag);
    check($sformatf("%s_rx_count", tag), rx.size(), exp_rx.size());
    for (int k = 0; k < exp_rx.size() && k < rx.size(); k++) begin
      check($sformatf("%s_rx%0d", tag, k), rx[k], exp_rx[k]);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < 40);
    check({tag, "_valid_seen"}, valid_o, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_o || src0.size() != 0 || src1.size() != 0) && n < 80);
    check({tag, "_idle"}, {30'd0, busy_o, (src0.size() != 0 || src1.size() != 0)}, 0);
  endtask

  initial begin
    reset    = 1'b1;
    ready    = 1'b1;
    cancel   = 1'b0;
    req_prot = {ipv4_pkg::PROT_ICMP, ipv4_pkg::PROT_UDP};

    // Reset values with both requesters already presenting beats.
    push_pkt(0, 16'hA000, 3);
    push_pkt(1, 16'hB000, 3);
    repeat (2) @(negedge clk);
    check("rst_valid", valid_o, 1'b0);
    check("rst_ready", req_ready, 2'b00);
    check("rst_abort", abort_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_owner", owner_o, 1'b0);
    check("rst_prot", prot_o, 8'd0);

    // Simultaneous requests: IDLE, ARB, then requester 0 streams.
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t1_idle_busy", busy_o, 1'b0);
    check("t1_idle_valid", valid_o, 1'b0);
    @(negedge clk);
    check("t1_arb_busy", busy_o, 1'b1);
    check("t1_arb_valid", valid_o, 1'b0);
    @(negedge clk);
    check("t1_x0_valid", valid_o, 1'b1);
    check("t1_x0_owner", owner_o, 1'b0);
    check("t1_x0_prot", prot_o, 8'd17);
    check("t1_x0_data", data_o, 16'hA000);
    check("t1_x0_ready", req_ready, 2'b01);
    repeat (2) @(negedge clk);
    check("t1_x2_data", data_o, 16'hA002);
    check("t1_x2_last", last_o, 1'b1);
    @(negedge clk);
    check("t1_gap_busy", busy_o, 1'b1);
    check("t1_gap_valid", valid_o, 1'b0);
    check("t1_gap_ready", req_ready, 2'b00);
    repeat (3) @(negedge clk);
    check("t1_b_valid", valid_o, 1'b1);
    check("t1_b_owner", owner_o, 1'b1);
    check("t1_b_prot", prot_o, 8'd1);
    check("t1_b_data", data_o, 16'hB000);
    check("t1_b_ready", req_ready, 2'b10);
    wait_idle("t1");
    exp_rx = '{16'hA000, 16'hA001, 16'hA002, 16'hB000, 16'hB001, 16'hB002};
    check_rx("t1");
    check("t1_grants", grants.size(), 2);
    clear_mon();

    // Requester 0 has back-to-back packets, requester 1 waits: alternation.
    push_pkt(0, 16'h1000, 2);
    push_pkt(0, 16'h1100, 1);
    push_pkt(1, 16'h2000, 2);
    push_pkt(1, 16'h2100, 1);
    wait_idle("t3");
    check("t3_grant_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) begin
      check($sformatf("t3_grant%0d", k), grants[k], k % 2);
    end
    exp_rx = '{16'h1000, 16'h1001, 16'h2000, 16'h2001, 16'h1100, 16'h2100};
    check_rx("t3");
    clear_mon();

    // Downstream stall for 3 cycles; packet sums to exactly MAX_LEN with last.
    push_pkt(0, 16'h3000, 4);
    wait_valid("t2");
    check("t2_first", data_o, 16'h3000);
    @(posedge clk); #1;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t2_stall%0d_valid", k), valid_o, 1'b1);
      check($sformatf("t2_stall%0d_ready", k), req_ready, 2'b00);
      check($sformatf("t2_stall%0d_data", k), data_o, 16'h3001);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    wait_idle("t2");
    exp_rx = '{16'h3000, 16'h3001, 16'h3002, 16'h3003};
    check_rx("t2");
    check("t2_no_abort", abort_cnt, 0);
    clear_mon();

    // Overrun: 6 beats of 2 bytes with MAX_LEN 8 aborts on the 4th transfer.
    push_pkt(0, 16'h4000, 6);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!abort_o && n < 40);
    end
    check("t4_abort_seen", abort_o, 1'b1);
    check("t4_abort_valid", valid_o, 1'b1);
    check("t4_abort_data", data_o, 16'h4003);
    check("t4_abort_last", last_o, 1'b0);
    @(negedge clk);
    check("t4_drain_valid", valid_o, 1'b0);
    check("t4_drain_ready", req_ready, 2'b01);
    check("t4_drain_abort", abort_o, 1'b0);
    wait_idle("t4");
    exp_rx = '{16'h4000, 16'h4001, 16'h4002, 16'h4003};
    check_rx("t4");
    check("t4_abort_count", abort_cnt, 1);
    clear_mon();

    // Cancel coinciding with the last beat; the other requester goes next.
    push_pkt(0, 16'h5000, 2);
    wait_valid("t6");
    check("t6_owner", owner_o, 1'b0);
    push_pkt(1, 16'h6000, 1);
    @(posedge clk); #1;
    cancel = 1'b1;
    @(negedge clk);
    check("t6_cancel_abort", abort_o, 1'b1);
    check("t6_cancel_valid", valid_o, 1'b0);
    check("t6_cancel_last", last_o, 1'b1);
    @(posedge clk); #1;
    cancel = 1'b0;
    wait_valid("t6_next");
    check("t6_next_owner", owner_o, 1'b1);
    check("t6_next_data", data_o, 16'h6000);
    wait_idle("t6");
    exp_rx = '{16'h5000, 16'h6000};
    check_rx("t6");
    check("t6_abort_count", abort_cnt, 1);
    clear_mon();

    // Reset mid-packet from requester 1; requester 0 must win afterwards.
    push_pkt(1, 16'h7000, 3);
    wait_valid("t7");
    check("t7_owner", owner_o, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t7_rst_valid", valid_o, 1'b0);
    check("t7_rst_ready", req_ready, 2'b00);
    check("t7_rst_abort", abort_o, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_pkt(0, 16'h8000, 1);
    @(negedge clk);
    check("t7_post_busy", busy_o, 1'b0);
    check("t7_post_valid", valid_o, 1'b0);
    wait_valid("t7_next");
    check("t7_next_owner", owner_o, 1'b0);
    check("t7_next_data", data_o, 16'h8000);
    wait_idle("t7");
    exp_rx = '{16'h7000, 16'h8000, 16'h7001, 16'h7002};
    check_rx("t7");
    check("t7_abort_count", abort_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
